// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with a one-entry stall buffer and redirect flush
// Registered fetch result drives decode; a redirect with a request in flight drains it in DISCARD.
module fetch_unit #(
  parameter logic [31:0] START_PC    = 32'h0000_0040,
  parameter logic [31:0] BUBBLE_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcCurrent,
  output logic [31:0] instWord,
  output logic        instValid
);

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;
  logic [31:0] discard_addr;
  logic [31:0] hold_pc;
  logic [31:0] hold_word;
  logic        hold_valid;
  logic        req_q;
  logic [31:0] target;
  logic        accept;

  assign target   = {redirectTarget[31:2], 2'b00};
  assign accept   = req_q && imemReady;
  assign imemReq  = req_q;
  // DISCARD keeps presenting the abandoned address until its response drains
  assign imemAddr = (state == DISCARD) ? discard_addr : fetch_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FETCH;
      fetch_pc     <= START_PC;
      discard_addr <= START_PC;
      hold_pc      <= START_PC;
      hold_word    <= BUBBLE_WORD;
      hold_valid   <= 1'b0;
      req_q        <= 1'b0;
      pcCurrent    <= START_PC;
      instWord     <= BUBBLE_WORD;
      instValid    <= 1'b0;
    end else if (redirect) begin
      fetch_pc   <= target;
      instValid  <= 1'b0;
      instWord   <= BUBBLE_WORD;
      hold_valid <= 1'b0;
      req_q      <= 1'b1;
      case (state)
        FETCH: begin
          if (req_q && !imemReady) begin
            state        <= DISCARD;
            discard_addr <= fetch_pc;
          end else begin
            state <= FETCH;
          end
        end
        DISCARD: state <= imemReady ? FETCH : DISCARD;
        default: state <= FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          req_q <= 1'b1;
          if (accept) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (stall) begin
              hold_pc    <= fetch_pc;
              hold_word  <= imemData;
              hold_valid <= 1'b1;
              req_q      <= 1'b0;
              state      <= HOLD;
            end else begin
              pcCurrent <= fetch_pc;
              instWord  <= imemData;
              instValid <= 1'b1;
            end
          end else if (!stall) begin
            instValid <= 1'b0;
            instWord  <= BUBBLE_WORD;
          end
        end
        HOLD: begin
          if (!stall) begin
            pcCurrent  <= hold_pc;
            instWord   <= hold_word;
            instValid  <= hold_valid;
            hold_valid <= 1'b0;
            req_q      <= 1'b1;
            state      <= FETCH;
          end
        end
        DISCARD: begin
          if (imemReady) begin
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
// Memory model returns address+1; inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  logic [31:0] pcCurrent;
  logic [31:0] instWord;
  logic        instValid;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .imemReq        (imemReq),
    .imemAddr       (imemAddr),
    .imemReady      (imemReady),
    .imemData       (imemData),
    .pcCurrent      (pcCurrent),
    .instWord       (instWord),
    .instValid      (instValid)
  );

  assign imemData = imemAddr + 32'd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirectTarget = 32'h0;
    imemReady      = 1'b0;
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] w);
    check({tag, "_valid"}, {31'b0, instValid}, {31'b0, v});
    check({tag, "_pc"}, pcCurrent, pc);
    check({tag, "_word"}, instWord, w);
  endtask

  initial begin
    reset_n        = 1'b0;
    stall          = 1'b0;
    redirect       = 1'b0;
    redirectTarget = 32'h0;
    imemReady      = 1'b0;
    @(negedge clk);

    // reset values and zero-wait streaming
    expect_out("rst", 1'b0, 32'h40, 32'h0);
    check("rst_req", {31'b0, imemReq}, 32'd0);
    reset_n   = 1'b1;
    imemReady = 1'b1;
    check("rel_req", {31'b0, imemReq}, 32'd0);
    step();
    check("first_req", {31'b0, imemReq}, 32'd1);
    check("first_addr", imemAddr, 32'h40);
    check("first_valid", {31'b0, instValid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("zw", 1'b1, 32'h40 + 32'(4 * i), 32'h41 + 32'(4 * i));
    end
    check("zw_next_addr", imemAddr, 32'h4C);

    // wait states at 0x40
    do_reset();
    for (int i = 0; i < 3; i++) begin
      check("ws_addr", imemAddr, 32'h40);
      step();
      check("ws_valid", {31'b0, instValid}, 32'd0);
      check("ws_word", instWord, 32'h0);
    end
    check("ws_addr4", imemAddr, 32'h40);
    imemReady = 1'b1;
    step();
    expect_out("ws_done", 1'b1, 32'h40, 32'h41);

    // stall while 0x44 returns
    do_reset();
    imemReady = 1'b1;
    step();
    expect_out("st_pre", 1'b1, 32'h40, 32'h41);
    stall = 1'b1;
    step();
    expect_out("st_h1", 1'b1, 32'h40, 32'h41);
    check("st_h1_req", {31'b0, imemReq}, 32'd0);
    step();
    expect_out("st_h2", 1'b1, 32'h40, 32'h41);
    check("st_h2_req", {31'b0, imemReq}, 32'd0);
    stall = 1'b0;
    step();
    expect_out("st_rel", 1'b1, 32'h44, 32'h45);
    check("st_rel_addr", imemAddr, 32'h48);
    step();
    expect_out("st_next", 1'b1, 32'h48, 32'h49);

    // redirect while waiting at 0x48; target low bits must be cleared
    do_reset();
    imemReady = 1'b1;
    step();
    step();
    imemReady = 1'b0;
    step();
    check("rd_wait_addr", imemAddr, 32'h48);
    redirect       = 1'b1;
    redirectTarget = 32'h0000_0103;
    step();
    redirect = 1'b0;
    expect_out("rd_flush", 1'b0, 32'h44, 32'h0);
    check("rd_disc_addr", imemAddr, 32'h48);
    check("rd_disc_req", {31'b0, imemReq}, 32'd1);
    step();
    check("rd_disc_addr2", imemAddr, 32'h48);
    imemReady = 1'b1;
    step();
    check("rd_drop_valid", {31'b0, instValid}, 32'd0);
    check("rd_new_addr", imemAddr, 32'h100);
    step();
    expect_out("rd_new", 1'b1, 32'h100, 32'h101);

    // redirect and stall together in HOLD
    do_reset();
    imemReady = 1'b1;
    step();
    stall = 1'b1;
    step();
    check("hr_hold_req", {31'b0, imemReq}, 32'd0);
    redirect       = 1'b1;
    redirectTarget = 32'h200;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    expect_out("hr_flush", 1'b0, 32'h40, 32'h0);
    check("hr_addr", imemAddr, 32'h200);
    step();
    expect_out("hr_new", 1'b1, 32'h200, 32'h201);

    // asynchronous reset pulse during DISCARD
    do_reset();
    imemReady = 1'b1;
    step();
    step();
    imemReady = 1'b0;
    step();
    redirect       = 1'b1;
    redirectTarget = 32'h300;
    step();
    redirect = 1'b0;
    check("ar_disc_addr", imemAddr, 32'h48);
    #2;
    reset_n = 1'b0;
    #1;
    expect_out("ar_rst", 1'b0, 32'h40, 32'h0);
    check("ar_rst_req", {31'b0, imemReq}, 32'd0);
    imemReady = 1'b1;
    reset_n   = 1'b1;
    @(negedge clk);
    check("ar_req", {31'b0, imemReq}, 32'd1);
    check("ar_addr", imemAddr, 32'h40);
    check("ar_valid", {31'b0, instValid}, 32'd0);
    step();
    expect_out("ar_first", 1'b1, 32'h40, 32'h41);

    // address wrap at the top of memory
    do_reset();
    imemReady      = 1'b1;
    redirect       = 1'b1;
    redirectTarget = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wr_addr", imemAddr, 32'hFFFF_FFFC);
    step();
    expect_out("wr_top", 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFD);
    check("wr_next_addr", imemAddr, 32'h0);
    step();
    expect_out("wr_zero", 1'b1, 32'h0, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
